// File: rtl/somador_pkg.sv
// Shared types for the somador arbiter: adder width, arbiter state and data word.
// Also holds the saturation helper used when SOMADOR_ARB_SAT_EN is defined.
package somador_pkg;

    localparam int SOM_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } som_arb_state_t;

    typedef logic [SOM_W-1:0] som_word_t;

    // Clamp the sum to all-ones whenever the adder overflowed.
    function automatic som_word_t sat_sum(
        input logic      cout,
        input som_word_t sum
    );
        return cout ? '1 : sum;
    endfunction

endpackage

// File: rtl/somador4.sv
// 4-bit adder: saida2 = low nibble of a+b+c, saida1 = carry-out.
// Ports: a, b (operands), c (carry-in), saida1 (carry-out), saida2 (sum).
module somador4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic       saida1,
    output logic [3:0] saida2
);

    assign {saida1, saida2} = {1'b0, a} + {1'b0, b} + {4'b0, c};

endmodule

// File: rtl/somador_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr.
// Ports: req_i, ptr_i in; win_oh_o (one-hot), win_idx_o, any_o out.
module somador_rr_pick
    import somador_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IW-1:0]   win_idx_o,
    output logic            any_o
);

    // One extra bit so ptr+k cannot overflow before the modulo wrap.
    logic [IW:0] cand;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any_o && req_i[cand[IW-1:0]]) begin
                any_o     = 1'b1;
                win_idx_o = cand[IW-1:0];
            end
        end
        if (any_o) begin
            win_oh_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/somador_arbiter.sv
// Round-robin arbiter sharing one somador4 among NREQ requesters (IDLE->EXEC->DONE).
// Ports: clk, reset (async low), req/op_a/op_b/op_c in; gnt, done, res_sum, res_cout, busy out.
// Optional macro SOMADOR_ARB_SAT_EN: saturate res_sum to 1111 on carry-out.
module somador_arbiter
    import somador_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [SOM_W*NREQ-1:0] op_a,
    input  logic [SOM_W*NREQ-1:0] op_b,
    input  logic [NREQ-1:0]       op_c,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output som_word_t             res_sum,
    output logic                  res_cout,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    som_arb_state_t state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   w_q, w_d;
    som_word_t       a_q, a_d;
    som_word_t       b_q, b_d;
    logic            c_q, c_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    som_word_t       sum_q, sum_d;
    logic            cout_q, cout_d;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    som_word_t       add_sum;
    logic            add_cout;

    somador_rr_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .win_oh_o (pick_oh),
        .win_idx_o(pick_idx),
        .any_o    (pick_any)
    );

    // The adder only ever sees the latched operands.
    somador4 u_add (
        .a     (a_q),
        .b     (b_q),
        .c     (c_q),
        .saida1(add_cout),
        .saida2(add_sum)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        gnt_d   = '0;
        done_d  = '0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    w_d     = pick_idx;
                    a_d     = op_a[SOM_W*int'(pick_idx) +: SOM_W];
                    b_d     = op_b[SOM_W*int'(pick_idx) +: SOM_W];
                    c_d     = op_c[pick_idx];
                    gnt_d   = pick_oh;
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifdef SOMADOR_ARB_SAT_EN
                sum_d = sat_sum(add_cout, add_sum);
`else
                sum_d = add_sum;
`endif
                cout_d       = add_cout;
                done_d[w_q]  = 1'b1;
                ptr_d        = (w_q == IW'(NREQ-1)) ? '0 : w_q + 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign res_sum  = sum_q;
    assign res_cout = cout_q;
    assign busy     = (state_q != IDLE);

endmodule
